// File: rtl/mem_block_copier.sv
// mem_block_copier: copies a byte block inside the 32x8 data memory.
// Ports: start/src/dst/length/abort in; busy/done/aborted/checksum out;
//        mem_address/mem_write_data/mem_write out, mem_read_data in.
module mem_block_copier #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [DATA_W-1:0] checksum,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W-1:0] r_rem;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_sum;
  logic              r_busy;
  logic              r_done;
  logic              r_aborted;

  logic w_rd;
  logic w_wr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_src     <= '0;
      r_dst     <= '0;
      r_rem     <= '0;
      r_data    <= '0;
      r_sum     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_src     <= src_addr;
            r_dst     <= dst_addr;
            r_rem     <= length;
            r_sum     <= '0;
            r_aborted <= 1'b0;
            r_busy    <= 1'b1;
            if (length == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_READ;
            end
          end
        end
        S_READ: begin
          if (abort) begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_aborted <= 1'b1;
          end else begin
            r_data  <= mem_read_data;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (abort) begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_aborted <= 1'b1;
          end else begin
            r_sum <= r_sum + r_data;
            r_src <= r_src + ADDR_W'(1);
            r_dst <= r_dst + ADDR_W'(1);
            r_rem <= r_rem - ADDR_W'(1);
            if (r_rem == ADDR_W'(1)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_READ;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign w_rd = (r_state == S_READ);
  assign w_wr = (r_state == S_WRITE);

  // abort must suppress the write in the very cycle it appears
  assign mem_write      = w_wr & ~abort;
  assign mem_address    = w_rd ? r_src : (w_wr ? r_dst : '0);
  assign mem_write_data = w_wr ? r_data : '0;

  assign busy     = r_busy;
  assign done     = r_done;
  assign aborted  = r_aborted;
  assign checksum = r_sum;

endmodule

// File: tb/tb_mem_block_copier.sv
// tb_mem_block_copier: directed + random copies against an array model.
// Owns the 32x8 memory with its reset image.
module tb_mem_block_copier;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] src_addr;
  logic [7:0] dst_addr;
  logic [7:0] length;
  logic       abort;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [7:0] checksum;
  logic [7:0] mem_address;
  logic [7:0] mem_write_data;
  logic       mem_write;
  logic [7:0] mem_read_data;

  logic [7:0] mem [32];
  logic [7:0] ref_mem [32];
  logic       img_load;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_block_copier #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .src_addr(src_addr),
    .dst_addr(dst_addr),
    .length(length),
    .abort(abort),
    .busy(busy),
    .done(done),
    .aborted(aborted),
    .checksum(checksum),
    .mem_address(mem_address),
    .mem_write_data(mem_write_data),
    .mem_write(mem_write),
    .mem_read_data(mem_read_data)
  );

  function automatic logic [7:0] img(int i);
    return (i < 16) ? 8'(i) : 8'(272 - i);
  endfunction

  always @(posedge clk) begin
    if (img_load) begin
      for (int i = 0; i < 32; i++) mem[i] <= img(i);
    end else if (mem_write) begin
      mem[mem_address[4:0]] <= mem_write_data;
    end
  end

  assign mem_read_data = mem[mem_address[4:0]];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic reload();
    img_load = 1'b1;
    @(negedge clk);
    img_load = 1'b0;
    for (int i = 0; i < 32; i++) ref_mem[i] = img(i);
  endtask

  task automatic chk_mem(input string tag);
    for (int i = 0; i < 32; i++)
      chk($sformatf("%s_mem%0d", tag, i), 32'(mem[i]), 32'(ref_mem[i]));
  endtask

  // acyc: cycle after the start edge in which abort is raised (0 = none)
  task automatic run(input logic [7:0] s, input logic [7:0] d,
                     input logic [7:0] l, input int acyc,
                     input string tag);
    int         nb;
    bit         ab;
    int         exp_done;
    logic [7:0] sum;
    int         dc;
    int         nwr;
    ab = (acyc != 0) && (acyc <= 2 * int'(l)) && (l != 0);
    nb = ab ? (acyc - 1) / 2 : int'(l);
    exp_done = ab ? acyc + 1 : 2 * int'(l) + 1;
    sum = 8'h00;
    for (int i = 0; i < nb; i++) begin
      ref_mem[(int'(d) + i) % 32] = ref_mem[(int'(s) + i) % 32];
      sum = sum + ref_mem[(int'(s) + i) % 32];
    end
    start = 1'b1;
    src_addr = s;
    dst_addr = d;
    length = l;
    abort = 1'($urandom_range(0, 1));
    @(negedge clk);
    start = 1'b0;
    dc = 0;
    nwr = 0;
    for (int c = 1; c <= 200; c++) begin
      abort = (c == acyc);
      #1;
      if (done) begin
        dc = c;
        break;
      end
      if (mem_write) nwr++;
      start = 1'($urandom_range(0, 1));
      src_addr = 8'($urandom);
      dst_addr = 8'($urandom);
      length = 8'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
    if (dc == 0) begin
      chk({tag, "_timeout"}, 32'(0), 32'(1));
    end else begin
      chk({tag, "_done_cyc"}, 32'(dc), 32'(exp_done));
      chk({tag, "_writes"}, 32'(nwr), 32'(nb));
      chk({tag, "_aborted"}, 32'(aborted), 32'(ab));
      chk({tag, "_checksum"}, 32'(checksum), 32'(sum));
      @(negedge clk);
      chk({tag, "_busy_after"}, 32'(busy), 32'(0));
      chk({tag, "_done_after"}, 32'(done), 32'(0));
      chk({tag, "_sum_held"}, 32'(checksum), 32'(sum));
      chk_mem(tag);
    end
  endtask

  initial begin
    reset = 1'b1;
    img_load = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    length = '0;
    for (int i = 0; i < 32; i++) ref_mem[i] = img(i);
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_aborted", 32'(aborted), 32'(0));
    chk("rst_checksum", 32'(checksum), 32'(0));
    chk("rst_mem_write", 32'(mem_write), 32'(0));
    chk("rst_mem_addr", 32'(mem_address), 32'(0));
    reset = 1'b0;
    img_load = 1'b0;
    @(negedge clk);

    abort = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_abort_busy", 32'(busy), 32'(0));
    chk("idle_abort_flag", 32'(aborted), 32'(0));
    abort = 1'b0;

    reload();
    run(8'd2, 8'd20, 8'd3, 0, "s1");
    reload();
    run(8'd5, 8'd9, 8'd0, 0, "s2");
    reload();
    run(8'd17, 8'd0, 8'd2, 0, "s3");
    reload();
    run(8'd30, 8'd5, 8'd4, 0, "s4");
    reload();
    run(8'd0, 8'd10, 8'd5, 6, "s5");

    reload();
    start = 1'b1;
    src_addr = 8'd2;
    dst_addr = 8'd20;
    length = 8'd3;
    @(negedge clk);
    start = 1'b1;
    src_addr = 8'd9;
    dst_addr = 8'd1;
    length = 8'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1;
    chk("s6_read2_addr", 32'(mem_address), 32'(3));
    reset = 1'b1;
    #1;
    chk("s6_busy", 32'(busy), 32'(0));
    chk("s6_checksum", 32'(checksum), 32'(0));
    chk("s6_mem_write", 32'(mem_write), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    ref_mem[20] = 8'h02;
    chk_mem("s6");

    for (int k = 0; k < 30; k++) begin
      logic [7:0] l;
      int a;
      l = 8'($urandom_range(0, 40));
      a = 0;
      if ($urandom_range(0, 2) == 0)
        a = int'($urandom_range(1, 2 * int'(l) + 2));
      run(8'($urandom), 8'($urandom), l, a, $sformatf("r%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
